bp_cache_dma_mem_responder: RTL and testbench

BP_CACHE_DMA_MEM_RESPONDER -- requirements
Module: bp_cache_dma_mem_responder

---
 rtl/bp_cache_dma_mem_responder.sv | 130 +++++++++++++
 tb/tb_bp_cache_dma_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cache_dma_mem_responder.sv
// DMA memory responder for a bsg_cache-style DMA port.
// Serves one burst at a time from a local backing store: read packets stream
// a block of fill beats to the cache, write packets absorb a block of evict
// beats. Transactions are strictly serialized in packet-acceptance order.
//
// state   | meaning
// --------+------------------------------------------------------------
// e_idle  | waiting for a DMA packet; the only state that accepts one
// e_read  | streaming mem[base+cnt] to the cache, one beat per handshake
// e_write | absorbing evict beats into mem[base+cnt], one per valid beat
module bp_cache_dma_mem_responder #(
    parameter int daddr_width_p = 28,
    parameter int fill_width_p  = 64,
    parameter int burst_len_p   = 8,
    parameter int mem_els_p     = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic [daddr_width_p:0]   dma_pkt_i,
    input  logic                     dma_pkt_v_i,
    output logic                     dma_pkt_ready_and_o,

    output logic [fill_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_ready_and_i,

    input  logic [fill_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o
);

    localparam int lg_fill_bytes_lp = $clog2(fill_width_p / 8);
    localparam int lg_burst_lp      = $clog2(burst_len_p);
    localparam int cnt_width_lp     = (lg_burst_lp > 0) ? lg_burst_lp : 1;
    localparam int idx_width_lp     = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(burst_len_p - 1);
    localparam logic [idx_width_lp-1:0] blk_mask_lp = ~idx_width_lp'(burst_len_p - 1);

    typedef enum logic [1:0] {
        e_idle,
        e_read,
        e_write
    } state_e;

    state_e                    state_r, state_n;
    logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
    logic [idx_width_lp-1:0]   base_r, base_n;
    logic [idx_width_lp-1:0]   pkt_base;
    logic [idx_width_lp-1:0]   idx;
    logic                      pkt_wnr;
    logic                      pkt_accept;
    logic                      beat_done;
    logic                      last_beat;

    logic [fill_width_p-1:0]   mem [mem_els_p];

    // Packet decode: byte address -> beat index, aligned down to the burst
    // boundary. Address bits above the store size drop out, so indices wrap.
    assign pkt_wnr  = dma_pkt_i[daddr_width_p];
    assign pkt_base = idx_width_lp'(dma_pkt_i[daddr_width_p-1:0] >> lg_fill_bytes_lp)
                      & blk_mask_lp;

    assign idx = base_r + idx_width_lp'(cnt_r);

    // Pkt ready is gated with reset so it reads 0 the moment reset asserts,
    // not only after the state register settles.
    assign dma_pkt_ready_and_o  = reset_n_i & (state_r == e_idle);
    assign dma_data_v_o         = (state_r == e_read);
    assign dma_data_ready_and_o = (state_r == e_write);
    assign dma_data_o           = mem[idx];

    assign pkt_accept = dma_pkt_v_i & dma_pkt_ready_and_o;
    assign beat_done  = ((state_r == e_read)  & dma_data_ready_and_i)
                      | ((state_r == e_write) & dma_data_v_i);
    assign last_beat  = (cnt_r == last_cnt_lp);

    // Next-state logic: launch on packet acceptance, step the beat counter on
    // each handshake, drop back to idle after the final beat of the burst.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        base_n  = base_r;
        unique case (state_r)
            e_idle: begin
                if (pkt_accept) begin
                    base_n  = pkt_base;
                    cnt_n   = '0;
                    state_n = pkt_wnr ? e_write : e_read;
                end
            end
            e_read, e_write: begin
                if (beat_done) begin
                    if (last_beat) begin
                        cnt_n   = '0;
                        state_n = e_idle;
                    end else begin
                        cnt_n = cnt_r + 1'b1;
                    end
                end
            end
            default: begin
                state_n = e_idle;
                cnt_n   = '0;
            end
        endcase
    end

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
            base_r  <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            base_r  <= base_n;
        end
    end

    // Backing store write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if ((state_r == e_write) && dma_data_v_i) begin
            mem[idx] <= dma_data_i;
        end
    end

endmodule

// File: tb/tb_bp_cache_dma_mem_responder.sv
// Randomized bench for bp_cache_dma_mem_responder with a flat array model of
// the backing store and per-beat ordering checks.
module tb_bp_cache_dma_mem_responder;

    localparam int daddr_w = 28;
    localparam int fill_w  = 64;
    localparam int burst   = 8;
    localparam int els     = 16;

    logic                clk_i = 1'b0;
    logic                reset_n_i;
    logic [daddr_w:0]    dma_pkt_i;
    logic                dma_pkt_v_i;
    logic                dma_pkt_ready_and_o;
    logic [fill_w-1:0]   dma_data_o;
    logic                dma_data_v_o;
    logic                dma_data_ready_and_i;
    logic [fill_w-1:0]   dma_data_i;
    logic                dma_data_v_i;
    logic                dma_data_ready_and_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [fill_w-1:0] ref_mem [els];

    bp_cache_dma_mem_responder #(
        .daddr_width_p(daddr_w),
        .fill_width_p (fill_w),
        .burst_len_p  (burst),
        .mem_els_p    (els)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .dma_pkt_i           (dma_pkt_i),
        .dma_pkt_v_i         (dma_pkt_v_i),
        .dma_pkt_ready_and_o (dma_pkt_ready_and_o),
        .dma_data_o          (dma_data_o),
        .dma_data_v_o        (dma_data_v_o),
        .dma_data_ready_and_i(dma_data_ready_and_i),
        .dma_data_i          (dma_data_i),
        .dma_data_v_i        (dma_data_v_i),
        .dma_data_ready_and_o(dma_data_ready_and_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat i of the burst addressed by a byte address: 8-byte beats, blocks of
    // 8 beats aligned, store of 16 beats wrapping.
    function automatic int blk_idx(input logic [daddr_w-1:0] addr, input int i);
        int beat_addr;
        beat_addr = int'(addr) / 8;
        return ((beat_addr / burst) * burst + i) % els;
    endfunction

    task automatic send_pkt(input bit wnr, input logic [daddr_w-1:0] addr, output bit ok);
        ok = 1'b0;
        @(negedge clk_i);
        dma_pkt_i   = {wnr, addr};
        dma_pkt_v_i = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (dma_pkt_ready_and_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) begin
            chk("pkt_accept_timeout", 64'd0, 64'd1);
            dma_pkt_v_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic do_write(input logic [daddr_w-1:0] addr, input bit fixed, input int n_beats);
        bit ok;
        logic [63:0] d;
        int gap;
        send_pkt(1'b1, addr, ok);
        if (!ok) return;
        for (int i = 0; i < n_beats; i++) begin
            gap = fixed ? 0 : int'($urandom_range(0, 2));
            repeat (gap) begin
                dma_data_v_i = 1'b0;
                dma_data_i   = {$urandom, $urandom};
                chk("wr_ready_gap", 64'(dma_data_ready_and_o), 64'd1);
                @(posedge clk_i);
                #1;
            end
            d = fixed ? 64'((i + 1) * 17) : {$urandom, $urandom};
            dma_data_v_i = 1'b1;
            dma_data_i   = d;
            chk("wr_ready", 64'(dma_data_ready_and_o), 64'd1);
            @(posedge clk_i);
            #1;
            ref_mem[blk_idx(addr, i)] = d;
        end
        dma_data_v_i = 1'b0;
        if (n_beats == burst) begin
            chk("wr_done_ready_o", 64'(dma_data_ready_and_o), 64'd0);
            chk("wr_done_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        end
    endtask

    // stall_beat < 0 selects random short stalls on every beat.
    task automatic do_read(input logic [daddr_w-1:0] addr, input int stall_beat, input int stall_len);
        bit ok;
        logic [63:0] e;
        int n_st;
        send_pkt(1'b0, addr, ok);
        if (!ok) return;
        // Evict-side traffic during a read must never reach the store.
        dma_data_v_i = 1'b1;
        for (int i = 0; i < burst; i++) begin
            e = ref_mem[blk_idx(addr, i)];
            if (stall_beat < 0) n_st = int'($urandom_range(0, 1));
            else                n_st = (i == stall_beat) ? stall_len : 0;
            repeat (n_st) begin
                dma_data_ready_and_i = 1'b0;
                dma_data_i = {$urandom, $urandom};
                chk("rd_hold_valid", 64'(dma_data_v_o), 64'd1);
                chk("rd_hold_data", dma_data_o, e);
                chk("rd_wr_ready_off", 64'(dma_data_ready_and_o), 64'd0);
                @(posedge clk_i);
                #1;
            end
            dma_data_ready_and_i = 1'b1;
            dma_data_i = {$urandom, $urandom};
            chk("rd_valid", 64'(dma_data_v_o), 64'd1);
            chk("rd_data", dma_data_o, e);
            @(posedge clk_i);
            #1;
        end
        dma_data_ready_and_i = 1'b0;
        dma_data_v_i         = 1'b0;
        chk("rd_done_valid", 64'(dma_data_v_o), 64'd0);
        chk("rd_done_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
    endtask

    initial begin
        bit                 wnr;
        logic [daddr_w-1:0] a;
        int acc [2];
        int na;
        int nb;
        bit drop_v;

        reset_n_i            = 1'b0;
        dma_pkt_i            = '0;
        dma_pkt_v_i          = 1'b0;
        dma_data_ready_and_i = 1'b0;
        dma_data_i           = '0;
        dma_data_v_i         = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("rst_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd0);
        chk("rst_data_v", 64'(dma_data_v_o), 64'd0);
        chk("rst_wr_ready", 64'(dma_data_ready_and_o), 64'd0);
        reset_n_i = 1'b1;
        #1;
        chk("post_rst_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);

        // Fill both blocks so every model entry is defined.
        do_write(28'h000, 1'b0, burst);
        do_write(28'h040, 1'b1, burst);
        do_read(28'h040, -1, 0);
        do_read(28'h048, 2, 3);

        // Wrap: beat index 16 lands on index 0.
        do_write(28'h080, 1'b0, burst);
        do_read(28'h000, -1, 0);

        for (int k = 0; k < 24; k++) begin
            wnr = 1'($urandom_range(0, 1));
            a   = daddr_w'($urandom);
            if (wnr) do_write(a, 1'b0, burst);
            else     do_read(a, -1, 0);
        end

        // Abort a write after three beats.
        do_write(28'h000, 1'b0, 3);
        reset_n_i = 1'b0;
        #1;
        chk("abort_wr_ready", 64'(dma_data_ready_and_o), 64'd0);
        chk("abort_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd0);
        chk("abort_data_v", 64'(dma_data_v_o), 64'd0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        chk("abort_release_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        do_read(28'h000, -1, 0);

        // Back-to-back reads with the packet held valid and the sink always ready.
        na = 0;
        nb = 0;
        drop_v = 1'b0;
        @(negedge clk_i);
        dma_pkt_i            = {1'b0, 28'h040};
        dma_pkt_v_i          = 1'b1;
        dma_data_ready_and_i = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (drop_v) dma_pkt_v_i = 1'b0;
            if (dma_data_v_o && dma_data_ready_and_i) begin
                chk("b2b_data", dma_data_o, ref_mem[8 + (nb % burst)]);
                nb++;
            end
            if (dma_pkt_v_i && dma_pkt_ready_and_o && na < 2) begin
                acc[na] = cyc;
                na++;
                if (na == 2) drop_v = 1'b1;
            end
            if (na == 2 && nb == 2 * burst) break;
            @(negedge clk_i);
        end
        dma_pkt_v_i          = 1'b0;
        dma_data_ready_and_i = 1'b0;
        chk("b2b_accepts", 64'(na), 64'd2);
        chk("b2b_beats", 64'(nb), 64'(2 * burst));
        if (na == 2) chk("b2b_spacing", 64'(acc[1] - acc[0]), 64'(burst + 1));

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
